// File: rtl/rv_regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package rv_regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    // Widest busy vector popcount accepts; NREGS must not exceed it.
    localparam int unsigned MAX_REGS      = 256;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: reservations, releases, pending count and
// sticky error for writebacks to registers that were never reserved.
module reg_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             wb_err
);

    logic [NREGS-1:0]    busy_d, busy_q;
    logic [AW:0]         busy_cnt_d, busy_cnt_q;
    logic                wb_err_d, wb_err_q;
    logic [MAX_REGS-1:0] busy_pad;
    logic                wb_hit;

    always_comb begin
        wb_hit      = wb_valid && (wb_rd != '0);
        // A same-cycle writeback to the target frees it in time for the new reservation.
        issue_ready = (issue_rd == '0) || !busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd));

        busy_d = busy_q;
        if (wb_hit) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue_valid && issue_ready && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        busy_pad               = '0;
        busy_pad[NREGS-1:0]    = busy_d;
        busy_cnt_d             = (AW+1)'(popcount(busy_pad));

        wb_err_d = wb_err_q || (wb_hit && !busy_q[wb_rd]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;
    assign wb_err   = wb_err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read-port register file with a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     busy_cnt,
    output logic            wb_err
);

    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             fwd1, fwd2;

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy        (busy),
        .busy_cnt    (busy_cnt),
        .wb_err      (wb_err)
    );

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && (wb_rd != '0)) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wb_valid && (wb_rd == rs1_addr) && (rs1_addr != '0);
    assign fwd2 = wb_valid && (wb_rd == rs2_addr) && (rs2_addr != '0);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = fwd1 ? wb_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = fwd2 ? wb_data : regs_q[rs2_addr];
        end
        rs1_busy = busy[rs1_addr] && !fwd1;
        rs2_busy = busy[rs2_addr] && !fwd2;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default 32x32 configuration).
module tb_regfile_scoreboard;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW:0]     busy_cnt;
    logic            wb_err;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy_cnt    (busy_cnt),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb_valid    = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        #1;
        rs1_addr = 5'd5;
        #1;
        check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
        check("rst_wb_err", 64'(wb_err), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_rs1_data", 64'(rs1_data), 64'd0);
        check("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reserve and release x7
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("rr_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        idle();
        rs1_addr = 5'd7;
        #1;
        check("rr_rs1_busy", 64'(rs1_busy), 64'd1);
        check("rr_busy_cnt1", 64'(busy_cnt), 64'd1);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        check("rr_rs1_data", 64'(rs1_data), 64'hDEADBEEF);
        check("rr_rs1_busy0", 64'(rs1_busy), 64'd0);
        check("rr_busy_cnt0", 64'(busy_cnt), 64'd0);
        check("rr_wb_err", 64'(wb_err), 64'd0);

        // WAW stall on x4
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        tick();
        #1;
        check("waw_stall", 64'(issue_ready), 64'd0);
        tick();
        check("waw_cnt_stalled", 64'(busy_cnt), 64'd1);
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 32'h0000_0044;
        #1;
        check("waw_ready_wb", 64'(issue_ready), 64'd1);
        tick();
        idle();
        rs1_addr = 5'd4;
        #1;
        check("waw_busy_kept", 64'(rs1_busy), 64'd1);
        check("waw_cnt_kept", 64'(busy_cnt), 64'd1);
        check("waw_data", 64'(rs1_data), 64'h44);
        check("waw_wb_err", 64'(wb_err), 64'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 32'h0000_0045;
        tick();
        idle();
        #1;
        check("waw_release_cnt", 64'(busy_cnt), 64'd0);

        // x0 is never written nor reserved
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        wb_valid    = 1'b1;
        wb_rd       = 5'd0;
        wb_data     = 32'h0000_1234;
        #1;
        check("x0_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        idle();
        rs1_addr = 5'd0;
        #1;
        check("x0_data", 64'(rs1_data), 64'd0);
        check("x0_busy", 64'(rs1_busy), 64'd0);
        check("x0_cnt", 64'(busy_cnt), 64'd0);
        check("x0_wb_err", 64'(wb_err), 64'd0);

        // Bypass on x9: preload 0x11111111, then reserve and write 0xA5A5A5A5
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        wb_data  = 32'h1111_1111;
        tick();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        idle();
        rs2_addr = 5'd9;
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        wb_data  = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rs2_data", 64'(rs2_data), 64'hA5A5A5A5);
        check("byp_rs2_busy", 64'(rs2_busy), 64'd0);
`else
        check("byp_rs2_data", 64'(rs2_data), 64'h11111111);
        check("byp_rs2_busy", 64'(rs2_busy), 64'd1);
`endif
        tick();
        idle();
        #1;
        check("byp_rs2_data_next", 64'(rs2_data), 64'hA5A5A5A5);
        check("byp_rs2_busy_next", 64'(rs2_busy), 64'd0);
        check("byp_cnt", 64'(busy_cnt), 64'd0);

        // Writeback to an unreserved register sets the sticky error
        wb_valid = 1'b1;
        wb_rd    = 5'd12;
        wb_data  = 32'hCAFE_F00D;
        #1;
        check("err_before_edge", 64'(wb_err), 64'd0);
        tick();
        idle();
        rs1_addr = 5'd12;
        #1;
        check("err_set", 64'(wb_err), 64'd1);
        check("err_data", 64'(rs1_data), 64'hCAFEF00D);
        tick();
        tick();
        check("err_sticky", 64'(wb_err), 64'd1);

        // Mid-run reset with three reservations outstanding
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        idle();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'h0000_0055;
        tick();
        idle();
        for (int r = 0; r < 3; r++) begin
            issue_valid = 1'b1;
            issue_rd    = (r == 0) ? 5'd5 : (r == 1) ? 5'd6 : 5'd8;
            tick();
        end
        idle();
        rs1_addr = 5'd5;
        #1;
        check("mr_cnt3", 64'(busy_cnt), 64'd3);
        check("mr_x5_pre", 64'(rs1_data), 64'h55);
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        wb_valid    = 1'b1;
        wb_rd       = 5'd6;
        wb_data     = 32'h0000_0066;
        #1;
        rst = 1'b1;
        #1;
        check("mr_cnt_async", 64'(busy_cnt), 64'd0);
        check("mr_wb_err", 64'(wb_err), 64'd0);
        check("mr_x5", 64'(rs1_data), 64'd0);
        check("mr_issue_ready", 64'(issue_ready), 64'd1);
        tick();
        check("mr_cnt_held", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rs1_addr = 5'd10;
        rs2_addr = 5'd6;
        tick();
        check("mr_x10_busy", 64'(rs1_busy), 64'd0);
        check("mr_x6_data", 64'(rs2_data), 64'd0);
        check("mr_cnt_after", 64'(busy_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
